// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcode codes, word layout,
// halt terminator and the control FSM state type.
package instr_encoder_pkg;

  localparam int unsigned OpW      = 3;
  localparam int unsigned OperandW = 6;
  localparam int unsigned InstrW   = OpW + OperandW;

  localparam logic [OpW-1:0] OpXor  = 3'd0;
  localparam logic [OpW-1:0] OpBeq  = 3'd1;
  localparam logic [OpW-1:0] OpAddi = 3'd2;
  localparam logic [OpW-1:0] OpAndi = 3'd3;
  localparam logic [OpW-1:0] OpLs   = 3'd4;
  localparam logic [OpW-1:0] OpLd   = 3'd5;
  localparam logic [OpW-1:0] OpSt   = 3'd6;
  localparam logic [OpW-1:0] OpJ    = 3'd7;

  // Jump with zero offset: the loaded program spins here once it finishes.
  localparam logic [InstrW-1:0] TermWord = {OpJ, 6'd0};

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StTerm,
    StDone
  } state_e;

  function automatic logic [InstrW-1:0] pack_instr(input logic [OpW-1:0]      op,
                                                   input logic [OperandW-1:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous staging FIFO with synchronous flush. Depth must be a power of two;
// push and pop may coincide on a full or empty buffer.
module enc_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, wptr_d;
  logic [PtrW:0]    rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrOne;
      if (do_pop)  rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into 9-bit words and streams them into instruction memory,
// appending a halt terminator. Optional word counter: define INSTR_ENCODER_COUNT_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDRW      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDRW-1:0]    base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OpW-1:0]      in_op,
  input  logic [OperandW-1:0] in_operand,
  input  logic                in_last,
  output logic                imem_we,
  output logic [ADDRW-1:0]    imem_addr,
  output logic [InstrW-1:0]   imem_wdata,
  output logic                busy,
  output logic                done,
`ifdef INSTR_ENCODER_COUNT_EN
  output logic [ADDRW:0]      word_count,
`endif
  output logic                overflow
);

  localparam logic [ADDRW-1:0] AddrMax = {ADDRW{1'b1}};
  localparam logic [ADDRW-1:0] AddrOne = 1;

  state_e            state_q, state_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              last_seen_q, last_seen_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [InstrW-1:0] fifo_rdata;
  logic              wrap_hit;
  logic              session_start;

  assign session_start = (state_q == StIdle) && start;
  assign fifo_pop      = (state_q == StLoad) && !fifo_empty;
  // A data word landing on the last address exhausts the space; abort without terminator.
  assign wrap_hit      = fifo_pop && (addr_q == AddrMax);
  assign fifo_push     = in_valid && in_ready;
  assign fifo_flush    = session_start || wrap_hit;

  enc_fifo #(
    .Width (InstrW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pack_instr(in_op, in_operand)),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      ovf_q       <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ovf_q       <= ovf_d;
      last_seen_q <= last_seen_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: begin
        if (wrap_hit)                       state_d = StDone;
        else if (last_seen_q && fifo_empty) state_d = StTerm;
      end
      StTerm: state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    ovf_d       = ovf_q;
    last_seen_d = last_seen_q;
    if (session_start) begin
      addr_d      = base_addr;
      ovf_d       = 1'b0;
      last_seen_d = 1'b0;
    end else begin
      if (imem_we)              addr_d      = addr_q + AddrOne;
      if (wrap_hit)             ovf_d       = 1'b1;
      if (fifo_push && in_last) last_seen_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    in_ready   = (state_q == StLoad) && !fifo_full && !last_seen_q && !wrap_hit;
    imem_we    = fifo_pop || (state_q == StTerm);
    imem_addr  = addr_q;
    imem_wdata = '0;
    if (fifo_pop)                imem_wdata = fifo_rdata;
    else if (state_q == StTerm)  imem_wdata = TermWord;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    overflow   = ovf_q;
  end

`ifdef INSTR_ENCODER_COUNT_EN
  localparam logic [ADDRW:0] CntOne = 1;

  logic [ADDRW:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q;
    if (session_start) word_count_d = '0;
    else if (imem_we)  word_count_d = word_count_q + CntOne;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) word_count_q <= '0;
    else       word_count_q <= word_count_d;
  end

  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed memory images.
module tb_instr_encoder;

  localparam int unsigned ADDRW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [ADDRW-1:0] base_addr;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [5:0]       in_operand;
  logic             in_last;
  logic             imem_we;
  logic [ADDRW-1:0] imem_addr;
  logic [8:0]       imem_wdata;
  logic             busy;
  logic             done;
  logic             overflow;
`ifdef INSTR_ENCODER_COUNT_EN
  logic [ADDRW:0]   word_count;
`endif

  instr_encoder #(
    .ADDRW      (ADDRW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
`ifdef INSTR_ENCODER_COUNT_EN
    .word_count (word_count),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [2:0]       s_op   [16];
  logic [5:0]       s_opnd [16];
  logic [ADDRW-1:0] exp_a  [16];
  logic [8:0]       exp_d  [16];
  logic [ADDRW-1:0] wr_a   [32];
  logic [8:0]       wr_d   [32];
  int               n_wr;
  int               gaps;
  logic             done_seen;
  logic             ovf_at_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [2:0] op, input logic [5:0] opnd);
    s_op[i]   = op;
    s_opnd[i] = opnd;
  endtask

  task automatic set_exp(input int i, input logic [ADDRW-1:0] a, input logic [8:0] d);
    exp_a[i] = a;
    exp_d[i] = d;
  endtask

  task automatic drive(input int idx, input int n);
    if (idx < n) begin
      in_valid   = 1'b1;
      in_op      = s_op[idx];
      in_operand = s_opnd[idx];
      in_last    = (idx == n - 1);
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Runs one session; inputs change just after rising edges, outputs are sampled on falling ones.
  task automatic run_session(input string tag, input logic [ADDRW-1:0] base, input int n);
    int  idx;
    logic acc;
    n_wr        = 0;
    gaps        = 0;
    done_seen   = 1'b0;
    ovf_at_done = 1'b0;
    idx         = 0;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive(idx, n);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (imem_we && n_wr < 32) begin
        wr_a[n_wr] = imem_addr;
        wr_d[n_wr] = imem_wdata;
        n_wr++;
      end
      if (idx < n && !in_ready) gaps++;
      acc = in_valid && in_ready;
      if (done) begin
        done_seen   = 1'b1;
        ovf_at_done = overflow;
        break;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      drive(idx, n);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq({tag, ".done_seen"}, 32'(done_seen), 32'd1);
    @(negedge clk);
    check_eq({tag, ".busy_after"}, 32'(busy), 32'd0);
    check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    check_eq({tag, ".nwr"}, n_wr, n_exp);
    for (int i = 0; i < n_exp && i < n_wr; i++) begin
      check_eq($sformatf("%s.addr%0d", tag, i), 32'(wr_a[i]), 32'(exp_a[i]));
      check_eq($sformatf("%s.data%0d", tag, i), 32'(wr_d[i]), 32'(exp_d[i]));
    end
  endtask

  initial begin
    int we_cnt;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    in_valid   = 1'b0;
    in_op      = '0;
    in_operand = '0;
    in_last    = 1'b0;
    #3;
    check_eq("rst.in_ready", 32'(in_ready), 32'd0);
    check_eq("rst.imem_we", 32'(imem_we), 32'd0);
    check_eq("rst.imem_addr", 32'(imem_addr), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // addi 0x05, xor 0x0A (last) from 0x10
    set_op(0, 3'd2, 6'h05);
    set_op(1, 3'd0, 6'h0A);
    set_exp(0, 8'h10, 9'h085);
    set_exp(1, 8'h11, 9'h00A);
    set_exp(2, 8'h12, 9'h1C0);
    run_session("basic", 8'h10, 2);
    check_writes("basic", 3);
    check_eq("basic.ovf", 32'(ovf_at_done), 32'd0);

    // six back-to-back ops from 0x40
    set_op(0, 3'd0, 6'h01);  set_exp(0, 8'h40, 9'h001);
    set_op(1, 3'd1, 6'h02);  set_exp(1, 8'h41, 9'h042);
    set_op(2, 3'd2, 6'h3F);  set_exp(2, 8'h42, 9'h0BF);
    set_op(3, 3'd3, 6'h10);  set_exp(3, 8'h43, 9'h0D0);
    set_op(4, 3'd4, 6'h00);  set_exp(4, 8'h44, 9'h100);
    set_op(5, 3'd6, 6'h2A);  set_exp(5, 8'h45, 9'h1AA);
    set_exp(6, 8'h46, 9'h1C0);
    run_session("b2b", 8'h40, 6);
    check_writes("b2b", 7);
    check_eq("b2b.ready_gaps", gaps, 0);

    // address space runs out: FE, FF written, third op dropped, no terminator
    set_op(0, 3'd5, 6'h11);  set_exp(0, 8'hFE, 9'h151);
    set_op(1, 3'd6, 6'h22);  set_exp(1, 8'hFF, 9'h1A2);
    set_op(2, 3'd7, 6'h33);
    run_session("wrap", 8'hFE, 3);
    check_writes("wrap", 2);
    check_eq("wrap.ovf", 32'(ovf_at_done), 32'd1);
    check_eq("wrap.ovf_sticky", 32'(overflow), 32'd1);

    // terminator lands on the last address legally
    set_op(0, 3'd3, 6'h07);  set_exp(0, 8'hFE, 9'h0C7);
    set_exp(1, 8'hFF, 9'h1C0);
    run_session("edge", 8'hFE, 1);
    check_writes("edge", 2);
    check_eq("edge.ovf", 32'(ovf_at_done), 32'd0);

    // reset in the middle of a load with data still staged
    @(negedge clk);
    start     = 1'b1;
    base_addr = 8'h20;
    @(posedge clk);
    #1;
    start      = 1'b0;
    in_valid   = 1'b1;
    in_op      = 3'd5;
    in_operand = 6'h01;
    @(posedge clk);
    #1;
    in_op      = 3'd6;
    in_operand = 6'h02;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("mid.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid.in_ready", 32'(in_ready), 32'd0);
    check_eq("mid.imem_we", 32'(imem_we), 32'd0);
    check_eq("mid.imem_addr", 32'(imem_addr), 32'd0);
    check_eq("mid.imem_wdata", 32'(imem_wdata), 32'd0);
    check_eq("mid.busy", 32'(busy), 32'd0);
    check_eq("mid.done", 32'(done), 32'd0);
    check_eq("mid.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (imem_we) we_cnt++;
    end
    check_eq("mid.no_writes", we_cnt, 0);

    set_op(0, 3'd1, 6'h15);  set_exp(0, 8'h30, 9'h055);
    set_exp(1, 8'h31, 9'h1C0);
    run_session("after_rst", 8'h30, 1);
    check_writes("after_rst", 2);

    // four-op session
    set_op(0, 3'd0, 6'h00);  set_exp(0, 8'h80, 9'h000);
    set_op(1, 3'd1, 6'h01);  set_exp(1, 8'h81, 9'h041);
    set_op(2, 3'd2, 6'h02);  set_exp(2, 8'h82, 9'h082);
    set_op(3, 3'd3, 6'h03);  set_exp(3, 8'h83, 9'h0C3);
    set_exp(4, 8'h84, 9'h1C0);
    run_session("four", 8'h80, 4);
    check_writes("four", 5);
`ifdef INSTR_ENCODER_COUNT_EN
    check_eq("four.word_count", 32'(word_count), 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
